csr_counter_bank: RTL and testbench

- Parametrised bank of machine-mode performance counters: the successor to the fixed MCYCLE/MINSTRET pair.
- Generalises to NUM_COUNTERS counters of COUNTER_WIDTH bits. Slot 0 is the cycle counter, slot 1 the instret counter, slots 2 and up are event counters.
- Adds per-counter inhibit, sticky overflow flags and 32-bit half-word CSR access with RW/RS/RC semantics.
- Sits beside the CSR file. Written from memory/writeback on CSR instructions; read by execute through a registered read port.

---
 rtl/csr_counter_bank.sv | 202 ++++++++++++++++++++
 tb/tb_csr_counter_bank.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/csr_counter_bank.sv
// csr_counter_bank: machine-mode performance counter bank with half-word CSR access,
// per-slot inhibit and sticky overflow. Define COUNTER_SNAPSHOT_EN for consistent low/high read pairs.
module csr_counter_bank #(
    parameter int NUM_COUNTERS  = 4,
    parameter int COUNTER_WIDTH = 64,
    parameter int INDEX_WIDTH   = 5
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    retireValid,
    input  logic [NUM_COUNTERS-1:0] eventPulse,
    input  logic                    readEnable,
    input  logic [INDEX_WIDTH-1:0]  readIndex,
    input  logic                    readHigh,
    output logic [31:0]             readData,
    output logic                    readValid,
    input  logic                    writeEnable,
    input  logic [INDEX_WIDTH-1:0]  writeIndex,
    input  logic                    writeHigh,
    input  logic [1:0]              writeOp,
    input  logic [31:0]             writeOperand,
    input  logic                    inhibitWrite,
    input  logic [NUM_COUNTERS-1:0] inhibitData,
    output logic [NUM_COUNTERS-1:0] countInhibit,
    output logic [NUM_COUNTERS-1:0] overflowFlag,
    input  logic [NUM_COUNTERS-1:0] overflowClear,
    output logic                    accessError
);
    localparam logic [1:0]               CSR_NONE = 2'b00;
    localparam logic [1:0]               CSR_RW   = 2'b01;
    localparam logic [1:0]               CSR_RS   = 2'b10;
    localparam logic [1:0]               CSR_RC   = 2'b11;
    localparam logic [31:0]              NUM_U    = 32'(NUM_COUNTERS);
    localparam logic [COUNTER_WIDTH-1:0] CNT_ONES = {COUNTER_WIDTH{1'b1}};
    localparam logic [COUNTER_WIDTH-1:0] CNT_ONE  = COUNTER_WIDTH'(1);

    // Counters narrower than 64 bits are viewed through a zero-extended 64-bit window.
    function automatic logic [63:0] widen(input logic [COUNTER_WIDTH-1:0] v);
        return 64'(v);
    endfunction

    logic [COUNTER_WIDTH-1:0] cnt_q [NUM_COUNTERS];
    logic [COUNTER_WIDTH-1:0] cnt_d [NUM_COUNTERS];
    logic [NUM_COUNTERS-1:0]  inhibit_q, inhibit_d;
    logic [NUM_COUNTERS-1:0]  ovf_q, ovf_d;
    logic [NUM_COUNTERS-1:0]  inc_s, wrap_s;
    logic [31:0]              read_data_q, read_data_d;
    logic                     read_valid_q, read_valid_d;
    logic                     access_error_q, access_error_d;
    logic [31:0]              rd_idx_s, wr_idx_s;
    logic                     rd_in_range_s, wr_in_range_s, wr_hit_s;
    logic [63:0]              rd_word_s, wr_word_s, wr_new_s;
    logic [31:0]              wr_half_old_s, wr_half_new_s, rd_high_s;

    // Index decode and read/write source selection from current state.
    always_comb begin
        rd_idx_s      = 32'(readIndex);
        wr_idx_s      = 32'(writeIndex);
        rd_in_range_s = (rd_idx_s < NUM_U);
        wr_in_range_s = (wr_idx_s < NUM_U);
        wr_hit_s      = writeEnable && (writeOp != CSR_NONE) && wr_in_range_s;
        rd_word_s     = 64'd0;
        wr_word_s     = 64'd0;
        for (int i = 0; i < NUM_COUNTERS; i++) begin
            rd_word_s |= (rd_idx_s == unsigned'(i)) ? widen(cnt_q[i]) : 64'd0;
            wr_word_s |= (wr_idx_s == unsigned'(i)) ? widen(cnt_q[i]) : 64'd0;
        end
    end

    // CSR read-modify-write of the selected half; the other half passes through.
    always_comb begin
        wr_half_old_s = writeHigh ? wr_word_s[63:32] : wr_word_s[31:0];
        case (writeOp)
            CSR_RW:  wr_half_new_s = writeOperand;
            CSR_RS:  wr_half_new_s = wr_half_old_s | writeOperand;
            CSR_RC:  wr_half_new_s = wr_half_old_s & ~writeOperand;
            default: wr_half_new_s = wr_half_old_s;
        endcase
        if (writeHigh) begin
            wr_new_s = {wr_half_new_s, wr_word_s[31:0]};
        end else begin
            wr_new_s = {wr_word_s[63:32], wr_half_new_s};
        end
    end

    // Per-slot increment, write priority and sticky overflow.
    always_comb begin
        for (int i = 0; i < NUM_COUNTERS; i++) begin
            if (i == 0) begin
                inc_s[i] = ~inhibit_q[i];
            end else if (i == 1) begin
                inc_s[i] = ~inhibit_q[i] & retireValid;
            end else begin
                inc_s[i] = ~inhibit_q[i] & eventPulse[i];
            end
            // A write to this slot swallows its increment, so it can never wrap this cycle.
            if (wr_hit_s && (wr_idx_s == unsigned'(i))) begin
                cnt_d[i]  = wr_new_s[COUNTER_WIDTH-1:0];
                wrap_s[i] = 1'b0;
            end else if (inc_s[i]) begin
                cnt_d[i]  = cnt_q[i] + CNT_ONE;
                wrap_s[i] = (cnt_q[i] == CNT_ONES);
            end else begin
                cnt_d[i]  = cnt_q[i];
                wrap_s[i] = 1'b0;
            end
            ovf_d[i] = wrap_s[i] | (ovf_q[i] & ~overflowClear[i]);
        end
        inhibit_d = inhibitWrite ? inhibitData : inhibit_q;
    end

`ifdef COUNTER_SNAPSHOT_EN
    logic                   snap_valid_q, snap_valid_d;
    logic [INDEX_WIDTH-1:0] snap_idx_q, snap_idx_d;
    logic [31:0]            snap_data_q, snap_data_d;

    // Low-half reads capture the upper half; any other read or a write to that slot drops it.
    always_comb begin
        snap_valid_d = snap_valid_q;
        snap_idx_d   = snap_idx_q;
        snap_data_d  = snap_data_q;
        if (readEnable) begin
            if (rd_in_range_s && !readHigh) begin
                snap_valid_d = 1'b1;
                snap_idx_d   = readIndex;
                snap_data_d  = rd_word_s[63:32];
            end else begin
                snap_valid_d = 1'b0;
            end
        end else begin
            snap_valid_d = snap_valid_q;
        end
        if (wr_hit_s && (writeIndex == snap_idx_d)) begin
            snap_valid_d = 1'b0;
        end else begin
            snap_valid_d = snap_valid_d;
        end
        rd_high_s = (snap_valid_q && (snap_idx_q == readIndex)) ? snap_data_q : rd_word_s[63:32];
    end

    // Snapshot register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            snap_valid_q <= 1'b0;
            snap_idx_q   <= {INDEX_WIDTH{1'b0}};
            snap_data_q  <= 32'd0;
        end else begin
            snap_valid_q <= snap_valid_d;
            snap_idx_q   <= snap_idx_d;
            snap_data_q  <= snap_data_d;
        end
    end
`else
    // High-half reads see the live counter.
    always_comb begin
        rd_high_s = rd_word_s[63:32];
    end
`endif

    // Read port result and out-of-range error, registered for one-cycle latency.
    always_comb begin
        read_valid_d = readEnable;
        if (!readEnable || !rd_in_range_s) begin
            read_data_d = 32'd0;
        end else if (readHigh) begin
            read_data_d = rd_high_s;
        end else begin
            read_data_d = rd_word_s[31:0];
        end
        access_error_d = (readEnable & ~rd_in_range_s) | (writeEnable & ~wr_in_range_s);
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < NUM_COUNTERS; i++) begin
                cnt_q[i] <= {COUNTER_WIDTH{1'b0}};
            end
            inhibit_q      <= {NUM_COUNTERS{1'b0}};
            ovf_q          <= {NUM_COUNTERS{1'b0}};
            read_data_q    <= 32'd0;
            read_valid_q   <= 1'b0;
            access_error_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_COUNTERS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            inhibit_q      <= inhibit_d;
            ovf_q          <= ovf_d;
            read_data_q    <= read_data_d;
            read_valid_q   <= read_valid_d;
            access_error_q <= access_error_d;
        end
    end

    assign readData     = read_data_q;
    assign readValid    = read_valid_q;
    assign accessError  = access_error_q;
    assign countInhibit = inhibit_q;
    assign overflowFlag = ovf_q;

endmodule

// File: tb/tb_csr_counter_bank.sv
// Bench for csr_counter_bank: directed CSR sequences checked against a 64-bit
// arithmetic model every cycle, plus hand-computed literal expectations.
module tb_csr_counter_bank;
    localparam int N  = 4;
    localparam int W  = 64;
    localparam int IW = 5;

    logic          clock, reset, retireValid;
    logic [N-1:0]  eventPulse;
    logic          readEnable, readHigh, readValid;
    logic [IW-1:0] readIndex;
    logic [31:0]   readData;
    logic          writeEnable, writeHigh;
    logic [IW-1:0] writeIndex;
    logic [1:0]    writeOp;
    logic [31:0]   writeOperand;
    logic          inhibitWrite;
    logic [N-1:0]  inhibitData, countInhibit, overflowFlag, overflowClear;
    logic          accessError;

    csr_counter_bank #(.NUM_COUNTERS(N), .COUNTER_WIDTH(W), .INDEX_WIDTH(IW)) dut (
        .clock(clock), .reset(reset), .retireValid(retireValid), .eventPulse(eventPulse),
        .readEnable(readEnable), .readIndex(readIndex), .readHigh(readHigh),
        .readData(readData), .readValid(readValid),
        .writeEnable(writeEnable), .writeIndex(writeIndex), .writeHigh(writeHigh),
        .writeOp(writeOp), .writeOperand(writeOperand),
        .inhibitWrite(inhibitWrite), .inhibitData(inhibitData), .countInhibit(countInhibit),
        .overflowFlag(overflowFlag), .overflowClear(overflowClear), .accessError(accessError)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural model: counters as plain 64-bit numbers.
    longint unsigned m_cnt [N];
    logic [N-1:0]    m_inh, m_ovf;
    logic            m_rv, m_err;
    logic [31:0]     m_rd;
    bit              m_snap_v;
    int              m_snap_i;
    logic [31:0]     m_snap_d;

    always @(posedge clock) begin
        longint unsigned v, nv;
        logic [31:0] h;
        bit inc;
        if (!reset) begin
            for (int i = 0; i < N; i++) m_cnt[i] = 64'd0;
            m_inh = '0; m_ovf = '0; m_rv = 1'b0; m_err = 1'b0; m_rd = 32'd0; m_snap_v = 1'b0;
        end else begin
            m_rv  = readEnable;
            m_err = (readEnable && readIndex >= N) || (writeEnable && writeIndex >= N);
            if (readEnable) begin
                if (readIndex < N) begin
                    v = m_cnt[readIndex];
                    if (!readHigh) begin
                        m_rd = v[31:0];
`ifdef COUNTER_SNAPSHOT_EN
                        m_snap_v = 1'b1; m_snap_i = int'(readIndex); m_snap_d = v[63:32];
`endif
                    end else begin
                        m_rd = v[63:32];
`ifdef COUNTER_SNAPSHOT_EN
                        if (m_snap_v && m_snap_i == int'(readIndex)) m_rd = m_snap_d;
                        m_snap_v = 1'b0;
`endif
                    end
                end else begin
                    m_rd = 32'd0;
                    m_snap_v = 1'b0;
                end
            end
            for (int i = 0; i < N; i++) begin
                inc = !m_inh[i] && (i == 0 || (i == 1 && retireValid) || (i >= 2 && eventPulse[i]));
                if (writeEnable && writeOp != 2'b00 && writeIndex == i) begin
                    v = m_cnt[i];
                    h = writeHigh ? v[63:32] : v[31:0];
                    h = (writeOp == 2'b01) ? writeOperand :
                        (writeOp == 2'b10) ? (h | writeOperand) : (h & ~writeOperand);
                    nv = writeHigh ? {h, v[31:0]} : {v[63:32], h};
                    m_cnt[i] = nv;
                    if (m_snap_i == i) m_snap_v = 1'b0;
                    if (overflowClear[i]) m_ovf[i] = 1'b0;
                end else if (inc && m_cnt[i] == 64'hFFFF_FFFF_FFFF_FFFF) begin
                    m_cnt[i] = 64'd0;
                    m_ovf[i] = 1'b1;
                end else begin
                    if (inc) m_cnt[i] = m_cnt[i] + 64'd1;
                    if (overflowClear[i]) m_ovf[i] = 1'b0;
                end
            end
            if (inhibitWrite) m_inh = inhibitData;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clock) begin
        chk("readValid", readValid, m_rv);
        if (m_rv) chk("readData", readData, m_rd);
        chk("accessError", accessError, m_err);
        chk("overflowFlag", overflowFlag, m_ovf);
        chk("countInhibit", countInhibit, m_inh);
    end

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic rd(input int idx, input bit hi, output logic [31:0] d);
        readEnable = 1'b1; readIndex = IW'(idx); readHigh = hi;
        tick();
        readEnable = 1'b0;
        d = readData;
    endtask

    task automatic wr(input int idx, input bit hi, input logic [1:0] op, input logic [31:0] val);
        writeEnable = 1'b1; writeIndex = IW'(idx); writeHigh = hi; writeOp = op; writeOperand = val;
        tick();
        writeEnable = 1'b0; writeOp = 2'b00;
    endtask

    logic [31:0] d0, d1, a, b, snap_exp;

    initial begin
        reset = 1'b0; retireValid = 1'b0; eventPulse = '0; readEnable = 1'b0; readIndex = '0;
        readHigh = 1'b0; writeEnable = 1'b0; writeIndex = '0; writeHigh = 1'b0; writeOp = 2'b00;
        writeOperand = 32'd0; inhibitWrite = 1'b0; inhibitData = '0; overflowClear = '0;
        repeat (3) tick();
        chk("reset_readValid", readValid, 1'b0);
        chk("reset_flags", overflowFlag, 4'h0);
        reset = 1'b1;
        repeat (10) tick();
        chk("idle_readValid", readValid, 1'b0);
        rd(0, 1'b0, d0); chk("cycle_after_reset", d0, 32'd10);
        for (int i = 1; i < N; i++) begin
            rd(i, 1'b0, d0); chk("slot_zero", d0, 32'd0);
        end

        // Carry across halves on slot 2.
        wr(2, 1'b0, 2'b01, 32'hFFFF_FFFF);
        eventPulse = 4'b0100; tick(); eventPulse = '0;
        rd(2, 1'b0, d0); chk("carry_low", d0, 32'h0);
        rd(2, 1'b1, d0); chk("carry_high", d0, 32'h1);

        // Wrap and sticky flag on slot 3.
        wr(3, 1'b0, 2'b01, 32'hFFFF_FFFF);
        wr(3, 1'b1, 2'b01, 32'hFFFF_FFFF);
        eventPulse = 4'b1000; tick(); eventPulse = '0;
        chk("wrap_flag", overflowFlag[3], 1'b1);
        rd(3, 1'b0, d0); chk("wrap_low", d0, 32'h0);
        rd(3, 1'b1, d0); chk("wrap_high", d0, 32'h0);
        repeat (3) tick();
        chk("flag_sticky", overflowFlag[3], 1'b1);
        overflowClear = 4'b1000; tick(); overflowClear = '0;
        chk("flag_cleared", overflowFlag[3], 1'b0);
        wr(3, 1'b0, 2'b01, 32'hFFFF_FFFF);
        wr(3, 1'b1, 2'b01, 32'hFFFF_FFFF);
        eventPulse = 4'b1000; overflowClear = 4'b1000; tick();
        eventPulse = '0; overflowClear = '0;
        chk("set_beats_clear", overflowFlag[3], 1'b1);
        overflowClear = 4'b1000; tick(); overflowClear = '0;

        // Write beats same-cycle retire increment.
        retireValid = 1'b1;
        wr(1, 1'b0, 2'b01, 32'h5);
        retireValid = 1'b0;
        rd(1, 1'b0, d0); chk("write_beats_inc", d0, 32'h5);

        // RW/RS/RC on slot 1.
        wr(1, 1'b0, 2'b01, 32'hF0);
        wr(1, 1'b0, 2'b10, 32'h0F);
        wr(1, 1'b0, 2'b11, 32'h3C);
        wr(1, 1'b0, 2'b00, 32'hFFFF);
        rd(1, 1'b0, d0); chk("rs_rc_result", d0, 32'hC3);

        // Inhibit slot 0 for 20 cycles.
        inhibitData = 4'b0001; inhibitWrite = 1'b1; tick(); inhibitWrite = 1'b0;
        chk("inhibit_mask", countInhibit, 4'b0001);
        rd(0, 1'b0, a);
        repeat (20) tick();
        rd(0, 1'b0, b); chk("inhibit_hold", b, a);
        inhibitData = 4'b0000; inhibitWrite = 1'b1; tick(); inhibitWrite = 1'b0;
        rd(0, 1'b0, d0); chk("uninhibit_first", d0, a);
        rd(0, 1'b0, d1); chk("uninhibit_next", d1, a + 32'd1);

        // Out-of-range read and write.
        rd(7, 1'b0, d0); chk("oor_read_data", d0, 32'h0);
        chk("oor_read_err", accessError, 1'b1);
        tick(); chk("oor_err_pulse", accessError, 1'b0);
        wr(7, 1'b0, 2'b01, 32'h1234);
        chk("oor_write_err", accessError, 1'b1);
        rd(1, 1'b0, d0); chk("oor_keep1", d0, 32'hC3);
        rd(2, 1'b0, d0); chk("oor_keep2lo", d0, 32'h0);
        rd(2, 1'b1, d0); chk("oor_keep2hi", d0, 32'h1);
        rd(3, 1'b0, d0); chk("oor_keep3", d0, 32'h0);

        // Low/high pair across a carry on slot 0.
        snap_exp = 32'd1;
`ifdef COUNTER_SNAPSHOT_EN
        snap_exp = 32'd0;
`endif
        wr(0, 1'b1, 2'b01, 32'h0);
        wr(0, 1'b0, 2'b01, 32'hFFFF_FFFF);
        rd(0, 1'b0, d0); chk("pair_low", d0, 32'hFFFF_FFFF);
        rd(0, 1'b1, d0); chk("pair_high", d0, snap_exp);

        // Reset mid-stream kills an in-flight read.
        readEnable = 1'b1; readIndex = '0; readHigh = 1'b0; reset = 1'b0;
        tick();
        readEnable = 1'b0; reset = 1'b1;
        chk("reset_kills_read", readValid, 1'b0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
